score_counter_display: RTL and testbench
========================================

Name: score_counter_display

Overview:
Multi-digit decimal score counter driving seven-segment displays. It generalises the single-digit point display to NUM_DIGITS cascaded BCD digits, with wrap or saturate on overflow and edge-detected increments. It also adds a clearable game score, a persistent high-score register and optional leading-zero blanking. It sits between the game-logic "pipe passed" strobe and the board HEX displays.

Parameters:
NUM_DIGITS, 2, number of BCD digits (1..6); digit 0 is least significant.
SATURATE, 0, 0 = wrap to all-zero after max (10^NUM_DIGITS - 1); 1 = hold at max.
ACTIVE_LOW_SEG, 1, 1 = segment outputs inverted (lit segment = 0), matching the board HEX displays.
BLANK_LEADING, 0, 1 = blank leading zero digits of the displayed score (digit 0 is never blanked).

Ports:
clk  input  1  system clock
reset  input  1  asynchronous, active-high reset
clear  input  1  synchronous game restart: zeroes score, keeps high score
up_count  input  1  level request; exactly one increment per 0->1 transition
hex  output  7*NUM_DIGITS  segment patterns, [7*i+6:7*i] = digit i, bit order g..a
score_bcd  output  4*NUM_DIGITS  current score, BCD
high_bcd  output  4*NUM_DIGITS  high score, BCD
new_high  output  1  level; set when the high score is raised in the current game
overflow  output  1  one-cycle pulse on an increment attempted at max

Behaviour:
- Reset (async, active-high) values: score = 0, high = 0, up_prev = 0, new_high = 0, overflow = 0. hex then shows "0" in digit 0. Other digits show "0", or blank if BLANK_LEADING = 1.
- Edge detect: up_prev <= up_count every cycle. inc = up_count & ~up_prev. A held-high up_count produces one increment only.
- Increment latency: inc sampled at edge k; score_bcd reflects the new value after edge k. No multi-cycle ripple: BCD carry propagates combinationally across all digits within one cycle.
- BCD arithmetic: each digit counts 0..9. Digit i increments when inc and all lower digits = 9, then 9 -> 0 with carry out. Digit values 10..15 are never produced. If one is forced, treat it as 9 for carry and display blank.
- At max (all digits 9) with inc: overflow = 1 for one cycle. SATURATE = 0 gives score -> 0; SATURATE = 1 leaves score unchanged.
- High score: if the next score > high (numeric BCD compare), then high <= next score and new_high <= 1 in the same edge. A wrap to 0 never lowers high. high is cleared only by reset.
- clear: score <= 0, new_high <= 0, overflow <= 0. clear beats a simultaneous inc; the edge is consumed (up_prev still updates), so no increment follows clear.
- reset asserted mid-increment: all state is cleared immediately, asynchronously. After deassertion, up_count held high causes no increment until it goes low then high again.
- hex: combinational decode of registered score_bcd, so there is no extra latency. Encodings, active-high g..a, before ACTIVE_LOW_SEG inversion:
  0 = 0111111, 1 = 0000110, 2 = 1011011, 3 = 1001111, 4 = 1100110, 5 = 1101101, 6 = 1111101, 7 = 0000111, 8 = 1111111, 9 = 1101111, blank = 0000000.
- Blanking with BLANK_LEADING = 1: digit i > 0 is blank when it and all higher digits are 0.
- The FSM is implicit in the digit registers. new_high forms a 2-state flag: IDLE -(high raised)-> NEW -(clear or reset)-> IDLE.

Decomposition:
- Package score_pkg:
  - typedef bcd_t (logic [3:0]) and seg_t (logic [6:0]).
  - Constants SEG_0..SEG_9 and SEG_BLANK.
  - Function bcd_to_seg(bcd_t, active_low) returning seg_t.
  - Function bcd_gt for the multi-digit compare.
- Sub-module bcd_digit holds one digit register with inc_in/clear/sat_hold inputs and value/carry_out outputs. It is instantiated NUM_DIGITS times in a generate loop, with carry chained from digit 0 upward.

Test Plan:
1. reset, then up_count pulsed 12 times (1 high / 1 low each) -> score_bcd = 0x12, hex[6:0] = ~SEG_2, hex[13:7] = ~SEG_1, high_bcd = 0x12, new_high = 1.
2. up_count held high 20 cycles after a 0 score -> score_bcd = 0x01 only; no further increments until it drops and rises again.
3. SATURATE = 0, score preset by 99 pulses to 0x99, one more pulse -> score_bcd = 0x00, overflow high exactly one cycle, high_bcd stays 0x99. With SATURATE = 1 -> score_bcd stays 0x99, overflow still pulses.
4. score 0x07, high 0x12, clear asserted on the same cycle as an up_count rising edge -> score_bcd = 0x00, new_high = 0, high_bcd = 0x12, no increment on the next cycle.
5. BLANK_LEADING = 1, NUM_DIGITS = 3, score 0x005 -> hex digit 2 and digit 1 = ~SEG_BLANK, digit 0 = ~SEG_5. At score 0x000, digit 0 = ~SEG_0.
6. reset asserted asynchronously between clock edges with score 0x34 -> score_bcd and high_bcd read 0 before the next edge. After release, up_count high gives no increment until a fresh 0->1.

Source files
------------

// File: rtl/score_pkg.sv
// Shared types, seven-segment encodings and BCD helpers for the score counter.
package score_pkg;

  localparam int MAX_DIGITS = 6;

  typedef logic [3:0] bcd_t;
  typedef logic [6:0] seg_t;

  typedef enum logic {
    HS_IDLE,
    HS_NEW
  } hs_state_t;

  // Any code above 9 decodes to an unlit digit.
  localparam bcd_t BCD_BLANK = 4'hF;

  localparam seg_t SEG_0     = 7'b0111111;
  localparam seg_t SEG_1     = 7'b0000110;
  localparam seg_t SEG_2     = 7'b1011011;
  localparam seg_t SEG_3     = 7'b1001111;
  localparam seg_t SEG_4     = 7'b1100110;
  localparam seg_t SEG_5     = 7'b1101101;
  localparam seg_t SEG_6     = 7'b1111101;
  localparam seg_t SEG_7     = 7'b0000111;
  localparam seg_t SEG_8     = 7'b1111111;
  localparam seg_t SEG_9     = 7'b1101111;
  localparam seg_t SEG_BLANK = 7'b0000000;

  function automatic seg_t bcd_to_seg(input bcd_t bcd, input logic active_low);
    seg_t seg;
    case (bcd)
      4'd0:    seg = SEG_0;
      4'd1:    seg = SEG_1;
      4'd2:    seg = SEG_2;
      4'd3:    seg = SEG_3;
      4'd4:    seg = SEG_4;
      4'd5:    seg = SEG_5;
      4'd6:    seg = SEG_6;
      4'd7:    seg = SEG_7;
      4'd8:    seg = SEG_8;
      4'd9:    seg = SEG_9;
      default: seg = SEG_BLANK;
    endcase
    return active_low ? ~seg : seg;
  endfunction

  function automatic bcd_t bcd_clamp(input bcd_t d);
    return (d > 4'd9) ? 4'd9 : d;
  endfunction

  // Numeric compare, most significant digit first; unused upper digits are zero.
  function automatic logic bcd_gt(input logic [4*MAX_DIGITS-1:0] a,
                                  input logic [4*MAX_DIGITS-1:0] b);
    logic gt;
    logic decided;
    bcd_t da;
    bcd_t db;
    gt      = 1'b0;
    decided = 1'b0;
    for (int i = MAX_DIGITS - 1; i >= 0; i--) begin
      da = bcd_clamp(a[4*i +: 4]);
      db = bcd_clamp(b[4*i +: 4]);
      if (!decided && (da != db)) begin
        gt      = (da > db);
        decided = 1'b1;
      end
    end
    return gt;
  endfunction

endpackage

// File: rtl/score_counter_display_bcd_digit.sv
// One decimal digit of the score: counts 0..9 and emits a combinational carry.
module bcd_digit
  import score_pkg::*;
(
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic inc_in,
  input  logic sat_hold,
  output bcd_t value,
  output bcd_t next_value,
  output logic carry_out
);

  bcd_t value_q;
  bcd_t value_d;

  // Out-of-range codes behave like 9 so the chain still rolls over cleanly.
  assign carry_out = inc_in & (value_q >= 4'd9);

  always_comb begin
    value_d = value_q;
    if (clear) begin
      value_d = '0;
    end else if (inc_in && !sat_hold) begin
      value_d = (value_q >= 4'd9) ? 4'd0 : value_q + 4'd1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      value_q <= '0;
    end else begin
      value_q <= value_d;
    end
  end

  assign value      = value_q;
  assign next_value = value_d;

endmodule

// File: rtl/score_counter_display.sv
// Multi-digit BCD score counter with high-score tracking and seven-segment drive.
module score_counter_display
  import score_pkg::*;
#(
  parameter int NUM_DIGITS     = 2,
  parameter int SATURATE       = 0,
  parameter int ACTIVE_LOW_SEG = 1,
  parameter int BLANK_LEADING  = 0
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    clear,
  input  logic                    up_count,
  output logic [7*NUM_DIGITS-1:0] hex,
  output logic [4*NUM_DIGITS-1:0] score_bcd,
  output logic [4*NUM_DIGITS-1:0] high_bcd,
  output logic                    new_high,
  output logic                    overflow
);

  logic                    up_prev_q, up_prev_d;
  logic                    arm_q, arm_d;
  logic [4*NUM_DIGITS-1:0] high_q, high_d;
  hs_state_t               hs_state_q, hs_state_d;
  logic                    overflow_q, overflow_d;

  logic                    inc;
  logic                    ovf_attempt;
  logic                    sat_hold;
  logic                    raise;
  logic [4*NUM_DIGITS-1:0] score_q;
  logic [4*NUM_DIGITS-1:0] score_next;
  logic [4*MAX_DIGITS-1:0] next_ext;
  logic [4*MAX_DIGITS-1:0] high_ext;

  // arm_q stays low after reset until up_count is seen low, so a level held
  // through reset is not mistaken for a fresh press.
  assign inc      = up_count & ~up_prev_q & arm_q;
  assign sat_hold = (SATURATE != 0) & ovf_attempt;

  for (genvar i = 0; i < NUM_DIGITS; i++) begin : g_digit
    logic dig_inc;
    logic dig_carry;
    bcd_t dig_value;
    bcd_t dig_next;

    if (i == 0) begin : g_lsd
      assign dig_inc = inc;
    end else begin : g_upper
      assign dig_inc = g_digit[i-1].dig_carry;
    end

    bcd_digit u_digit (
      .clk        (clk),
      .reset      (reset),
      .clear      (clear),
      .inc_in     (dig_inc),
      .sat_hold   (sat_hold),
      .value      (dig_value),
      .next_value (dig_next),
      .carry_out  (dig_carry)
    );

    assign score_q[4*i +: 4]    = dig_value;
    assign score_next[4*i +: 4] = dig_next;
  end

  assign ovf_attempt = g_digit[NUM_DIGITS-1].dig_carry;

  always_comb begin
    next_ext                      = '0;
    high_ext                      = '0;
    next_ext[4*NUM_DIGITS-1:0]    = score_next;
    high_ext[4*NUM_DIGITS-1:0]    = high_q;
  end

  assign raise = ~clear & bcd_gt(next_ext, high_ext);

  always_comb begin
    up_prev_d  = up_count;
    arm_d      = arm_q | ~up_count;
    overflow_d = ovf_attempt & ~clear;
    high_d     = high_q;
    hs_state_d = hs_state_q;
    if (raise) begin
      high_d = score_next;
    end
    case (hs_state_q)
      HS_IDLE: if (raise) hs_state_d = HS_NEW;
      HS_NEW:  if (clear) hs_state_d = HS_IDLE;
      default: hs_state_d = HS_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      up_prev_q  <= 1'b0;
      arm_q      <= 1'b0;
      high_q     <= '0;
      hs_state_q <= HS_IDLE;
      overflow_q <= 1'b0;
    end else begin
      up_prev_q  <= up_prev_d;
      arm_q      <= arm_d;
      high_q     <= high_d;
      hs_state_q <= hs_state_d;
      overflow_q <= overflow_d;
    end
  end

  // Decode scans from the top digit down so the leading-zero run is known per digit.
  always_comb begin
    logic zero_run;
    logic blank;
    bcd_t d;
    hex      = '0;
    zero_run = 1'b1;
    for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
      d        = score_q[4*i +: 4];
      zero_run = zero_run & (d == 4'd0);
      blank    = (BLANK_LEADING != 0) && (i != 0) && zero_run;
      hex[7*i +: 7] = bcd_to_seg(blank ? BCD_BLANK : d, ACTIVE_LOW_SEG != 0);
    end
  end

  assign score_bcd = score_q;
  assign high_bcd  = high_q;
  assign new_high  = (hs_state_q == HS_NEW);
  assign overflow  = overflow_q;

endmodule

// File: tb/tb_score_counter_display.sv
// Directed bench: default wrap counter, saturating variant and 3-digit blanking variant.
module tb_score_counter_display;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic up_a = 1'b0, up_s = 1'b0, up_b = 1'b0;
  logic clr_a = 1'b0, clr_s = 1'b0, clr_b = 1'b0;

  logic [13:0] hex_a, hex_s;
  logic [20:0] hex_b;
  logic [7:0]  score_a, high_a, score_s, high_s;
  logic [11:0] score_b, high_b;
  logic        nh_a, ovf_a, nh_s, ovf_s, nh_b, ovf_b;

  int checks = 0;
  int errors = 0;

  localparam logic [6:0] L0 = 7'b1000000;
  localparam logic [6:0] L1 = 7'b1111001;
  localparam logic [6:0] L2 = 7'b0100100;
  localparam logic [6:0] L5 = 7'b0010010;
  localparam logic [6:0] LB = 7'b1111111;

  always #5 clk = ~clk;

  score_counter_display dut_a (
    .clk(clk), .reset(reset), .clear(clr_a), .up_count(up_a), .hex(hex_a),
    .score_bcd(score_a), .high_bcd(high_a), .new_high(nh_a), .overflow(ovf_a)
  );

  score_counter_display #(.SATURATE(1)) dut_s (
    .clk(clk), .reset(reset), .clear(clr_s), .up_count(up_s), .hex(hex_s),
    .score_bcd(score_s), .high_bcd(high_s), .new_high(nh_s), .overflow(ovf_s)
  );

  score_counter_display #(.NUM_DIGITS(3), .BLANK_LEADING(1)) dut_b (
    .clk(clk), .reset(reset), .clear(clr_b), .up_count(up_b), .hex(hex_b),
    .score_bcd(score_b), .high_bcd(high_b), .new_high(nh_b), .overflow(ovf_b)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse(input logic [2:0] mask, input int n);
    for (int k = 0; k < n; k++) begin
      up_a = mask[0]; up_s = mask[1]; up_b = mask[2];
      tick();
      up_a = 1'b0; up_s = 1'b0; up_b = 1'b0;
      tick();
    end
  endtask

  task automatic do_clear(input logic [2:0] mask);
    clr_a = mask[0]; clr_s = mask[1]; clr_b = mask[2];
    tick();
    clr_a = 1'b0; clr_s = 1'b0; clr_b = 1'b0;
  endtask

  task automatic do_reset();
    up_a = 1'b0; up_s = 1'b0; up_b = 1'b0;
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    tick();
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (score_a !== 8'h00) begin errors++; $display("FAIL reset_score: got %h expected 00", score_a); end
    checks++; if (high_a !== 8'h00) begin errors++; $display("FAIL reset_high: got %h expected 00", high_a); end
    checks++; if (nh_a !== 1'b0 || ovf_a !== 1'b0) begin errors++; $display("FAIL reset_flags: got nh=%b ovf=%b expected 0 0", nh_a, ovf_a); end
    checks++; if (hex_a !== {L0, L0}) begin errors++; $display("FAIL reset_hex: got %b expected %b", hex_a, {L0, L0}); end
    checks++; if (hex_b !== {LB, LB, L0}) begin errors++; $display("FAIL reset_hex_blank: got %b expected %b", hex_b, {LB, LB, L0}); end
  endtask

  task automatic test_count();
    pulse(3'b001, 12);
    checks++; if (score_a !== 8'h12) begin errors++; $display("FAIL count_score: got %h expected 12", score_a); end
    checks++; if (hex_a !== {L1, L2}) begin errors++; $display("FAIL count_hex: got %b expected %b", hex_a, {L1, L2}); end
    checks++; if (high_a !== 8'h12) begin errors++; $display("FAIL count_high: got %h expected 12", high_a); end
    checks++; if (nh_a !== 1'b1) begin errors++; $display("FAIL count_new_high: got %b expected 1", nh_a); end
  endtask

  task automatic test_hold();
    do_clear(3'b001);
    up_a = 1'b1;
    tick();
    checks++; if (score_a !== 8'h01) begin errors++; $display("FAIL hold_first: got %h expected 01", score_a); end
    for (int k = 0; k < 19; k++) tick();
    checks++; if (score_a !== 8'h01) begin errors++; $display("FAIL hold_level: got %h expected 01", score_a); end
    up_a = 1'b0;
    tick();
    up_a = 1'b1;
    tick();
    checks++; if (score_a !== 8'h02) begin errors++; $display("FAIL hold_reedge: got %h expected 02", score_a); end
    up_a = 1'b0;
    tick();
    checks++; if (nh_a !== 1'b0 || high_a !== 8'h12) begin errors++; $display("FAIL hold_high_kept: got nh=%b high=%h expected 0 12", nh_a, high_a); end
  endtask

  task automatic test_overflow();
    do_clear(3'b011);
    pulse(3'b011, 99);
    checks++; if (score_a !== 8'h99 || score_s !== 8'h99) begin errors++; $display("FAIL ovf_preset: got %h %h expected 99 99", score_a, score_s); end
    checks++; if (ovf_a !== 1'b0) begin errors++; $display("FAIL ovf_early: got %b expected 0", ovf_a); end
    up_a = 1'b1; up_s = 1'b1;
    tick();
    checks++; if (score_a !== 8'h00) begin errors++; $display("FAIL ovf_wrap: got %h expected 00", score_a); end
    checks++; if (hex_a !== {L0, L0}) begin errors++; $display("FAIL ovf_wrap_hex: got %b expected %b", hex_a, {L0, L0}); end
    checks++; if (score_s !== 8'h99) begin errors++; $display("FAIL ovf_sat: got %h expected 99", score_s); end
    checks++; if (ovf_a !== 1'b1 || ovf_s !== 1'b1) begin errors++; $display("FAIL ovf_pulse: got %b %b expected 1 1", ovf_a, ovf_s); end
    up_a = 1'b0; up_s = 1'b0;
    tick();
    checks++; if (ovf_a !== 1'b0 || ovf_s !== 1'b0) begin errors++; $display("FAIL ovf_one_cycle: got %b %b expected 0 0", ovf_a, ovf_s); end
    checks++; if (high_a !== 8'h99 || high_s !== 8'h99) begin errors++; $display("FAIL ovf_high: got %h %h expected 99 99", high_a, high_s); end
  endtask

  task automatic test_clear_vs_inc();
    do_reset();
    pulse(3'b001, 12);
    do_clear(3'b001);
    pulse(3'b001, 7);
    checks++; if (score_a !== 8'h07 || high_a !== 8'h12 || nh_a !== 1'b0) begin errors++; $display("FAIL clr_setup: got %h %h %b expected 07 12 0", score_a, high_a, nh_a); end
    up_a = 1'b1; clr_a = 1'b1;
    tick();
    checks++; if (score_a !== 8'h00) begin errors++; $display("FAIL clr_score: got %h expected 00", score_a); end
    checks++; if (nh_a !== 1'b0 || high_a !== 8'h12) begin errors++; $display("FAIL clr_high: got nh=%b high=%h expected 0 12", nh_a, high_a); end
    clr_a = 1'b0;
    tick();
    checks++; if (score_a !== 8'h00) begin errors++; $display("FAIL clr_consumed: got %h expected 00", score_a); end
    up_a = 1'b0;
    tick();
  endtask

  task automatic test_blank();
    do_clear(3'b100);
    pulse(3'b100, 5);
    checks++; if (score_b !== 12'h005) begin errors++; $display("FAIL blank_score: got %h expected 005", score_b); end
    checks++; if (hex_b !== {LB, LB, L5}) begin errors++; $display("FAIL blank_hex5: got %b expected %b", hex_b, {LB, LB, L5}); end
    do_clear(3'b100);
    checks++; if (hex_b !== {LB, LB, L0}) begin errors++; $display("FAIL blank_hex0: got %b expected %b", hex_b, {LB, LB, L0}); end
    pulse(3'b100, 10);
    checks++; if (hex_b !== {LB, L1, L0}) begin errors++; $display("FAIL blank_hex10: got %b expected %b", hex_b, {LB, L1, L0}); end
  endtask

  task automatic test_async_reset();
    do_reset();
    pulse(3'b001, 34);
    checks++; if (score_a !== 8'h34) begin errors++; $display("FAIL areset_setup: got %h expected 34", score_a); end
    up_a = 1'b1;
    #2 reset = 1'b1;
    #1;
    checks++; if (score_a !== 8'h00 || high_a !== 8'h00) begin errors++; $display("FAIL areset_immediate: got %h %h expected 00 00", score_a, high_a); end
    #2 reset = 1'b0;
    tick();
    tick();
    tick();
    checks++; if (score_a !== 8'h00) begin errors++; $display("FAIL areset_held: got %h expected 00", score_a); end
    up_a = 1'b0;
    tick();
    up_a = 1'b1;
    tick();
    checks++; if (score_a !== 8'h01) begin errors++; $display("FAIL areset_fresh_edge: got %h expected 01", score_a); end
    up_a = 1'b0;
    tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_count();
    test_hold();
    test_overflow();
    test_clear_vs_inc();
    test_blank();
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
